// File: rtl/dual_issue_scheduler.sv
// Issue scheduler for the 2-way MIPS core: holds one fetched pair, checks
// intra-pair hazards, and issues the pair together or split over two cycles.
module dual_issue_scheduler #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             f_valid,
  output logic             f_ready,
  input  logic [31:0]      f_instr_0,
  input  logic [31:0]      f_instr_1,
  input  logic             iss_ready,
  input  logic             flush,
  output logic             iss_valid_0,
  output logic [31:0]      iss_instr_0,
  output logic             iss_valid_1,
  output logic [31:0]      iss_instr_1,
  output logic [CNT_W-1:0] cnt_dual,
  output logic [CNT_W-1:0] cnt_single,
  output logic [CNT_W-1:0] cnt_stall
);

  typedef enum logic [1:0] {EMPTY, FULL, SPLIT} state_t;

  typedef struct packed {
    logic       has_dst;
    logic [4:0] dst;
    logic       use_rs;
    logic       use_rt;
    logic       mem;
    logic       ctrl;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    d = '0;
    case (instr[31:26])
      6'h00: begin
        if (instr != 32'h0) begin
          d.has_dst = 1'b1;
          d.dst     = instr[15:11];
          d.use_rs  = 1'b1;
          d.use_rt  = 1'b1;
        end
      end
      6'h08, 6'h0A, 6'h0C, 6'h0D: begin
        d.has_dst = 1'b1;
        d.dst     = instr[20:16];
        d.use_rs  = 1'b1;
      end
      6'h23: begin
        d.has_dst = 1'b1;
        d.dst     = instr[20:16];
        d.use_rs  = 1'b1;
        d.mem     = 1'b1;
      end
      6'h2B: begin
        d.use_rs = 1'b1;
        d.use_rt = 1'b1;
        d.mem    = 1'b1;
      end
      6'h04, 6'h05: begin
        d.use_rs = 1'b1;
        d.use_rt = 1'b1;
        d.ctrl   = 1'b1;
      end
      6'h02: d.ctrl = 1'b1;
      default: ;
    endcase
    // Writes to $0 are discarded, so they can never create a hazard.
    if (d.dst == 5'd0) begin
      d.has_dst = 1'b0;
    end
    return d;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] buf0_q, buf0_d;
  logic [31:0] buf1_q, buf1_d;

  dec_t dec0, dec1;
  logic conflict;
  logic fire;
  logic drained;

  always_comb begin
    dec0 = decode(buf0_q);
    dec1 = decode(buf1_q);
    conflict = dec0.ctrl
            || (dec0.mem && dec1.mem)
            || (dec0.has_dst && dec1.use_rs  && (buf1_q[25:21] == dec0.dst))
            || (dec0.has_dst && dec1.use_rt  && (buf1_q[20:16] == dec0.dst))
            || (dec0.has_dst && dec1.has_dst && (dec1.dst == dec0.dst));
  end

  always_comb begin
    iss_valid_0 = 1'b0;
    iss_instr_0 = 32'h0;
    iss_valid_1 = 1'b0;
    iss_instr_1 = 32'h0;
    case (state_q)
      FULL: begin
        iss_valid_0 = 1'b1;
        iss_instr_0 = buf0_q;
        if (!conflict) begin
          iss_valid_1 = 1'b1;
          iss_instr_1 = buf1_q;
        end
      end
      SPLIT: begin
        iss_valid_0 = 1'b1;
        iss_instr_0 = buf1_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    fire    = iss_ready && iss_valid_0;
    drained = fire && ((state_q == SPLIT) || iss_valid_1);
    f_ready = !flush && ((state_q == EMPTY) || drained);

    state_d = state_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      if (fire) begin
        state_d = drained ? EMPTY : SPLIT;
      end
      // A newly accepted pair overrides the drain transition above.
      if (f_valid && f_ready) begin
        state_d = FULL;
        buf0_d  = f_instr_0;
        buf1_d  = f_instr_1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= EMPTY;
      buf0_q  <= 32'h0;
      buf1_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
    end
  end

  // Counter order: 0 = dual issue, 1 = single issue, 2 = stall.
  logic [2:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  always_comb begin
    cnt_inc[0] = fire && iss_valid_1;
    cnt_inc[1] = fire && !iss_valid_1;
    cnt_inc[2] = (state_q != EMPTY) && !iss_ready;
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      always_comb begin
        cnt_d[gi] = cnt_q[gi];
        if (cnt_inc[gi] && (cnt_q[gi] != {CNT_W{1'b1}})) begin
          cnt_d[gi] = cnt_q[gi] + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (Reset) begin
          cnt_q[gi] <= '0;
        end else begin
          cnt_q[gi] <= cnt_d[gi];
        end
      end
    end
  endgenerate

  assign cnt_dual   = cnt_q[0];
  assign cnt_single = cnt_q[1];
  assign cnt_stall  = cnt_q[2];

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Scoreboard bench for dual_issue_scheduler: stimulus queues expected issues,
// a negedge monitor checks every fired issue against the queue.
module tb_dual_issue_scheduler;

  localparam int CNT_W = 4;

  localparam logic [31:0] ADD_1_2_3  = 32'h00430820;
  localparam logic [31:0] ADD_4_5_6  = 32'h00A62020;
  localparam logic [31:0] SUB_4_1_5  = 32'h00252022;
  localparam logic [31:0] LW_2_0_1   = 32'h8C220000;
  localparam logic [31:0] SW_3_4_4   = 32'hAC830004;
  localparam logic [31:0] BEQ_1_2    = 32'h10220010;
  localparam logic [31:0] ADD_3_4_5  = 32'h00851820;
  localparam logic [31:0] ADDI_1_4_7 = 32'h20810007;
  localparam logic [31:0] ADD_0_2_3  = 32'h00430020;
  localparam logic [31:0] ADD_4_0_5  = 32'h00052020;
  localparam logic [31:0] SW_3_4_1   = 32'hAC230004;
  localparam logic [31:0] J_10       = 32'h08000010;

  logic             clk;
  logic             Reset;
  logic             f_valid;
  logic             f_ready;
  logic [31:0]      f_instr_0;
  logic [31:0]      f_instr_1;
  logic             iss_ready;
  logic             flush;
  logic             iss_valid_0;
  logic [31:0]      iss_instr_0;
  logic             iss_valid_1;
  logic [31:0]      iss_instr_1;
  logic [CNT_W-1:0] cnt_dual;
  logic [CNT_W-1:0] cnt_single;
  logic [CNT_W-1:0] cnt_stall;

  dual_issue_scheduler #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .f_valid    (f_valid),
    .f_ready    (f_ready),
    .f_instr_0  (f_instr_0),
    .f_instr_1  (f_instr_1),
    .iss_ready  (iss_ready),
    .flush      (flush),
    .iss_valid_0(iss_valid_0),
    .iss_instr_0(iss_instr_0),
    .iss_valid_1(iss_valid_1),
    .iss_instr_1(iss_instr_1),
    .cnt_dual   (cnt_dual),
    .cnt_single (cnt_single),
    .cnt_stall  (cnt_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v1;
    logic [31:0] i0;
    logic [31:0] i1;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic v1, input logic [31:0] i0, input logic [31:0] i1);
    exp_t e;
    e.v1 = v1;
    e.i0 = i0;
    e.i1 = i1;
    exp_q.push_back(e);
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic offer(input logic [31:0] i0, input logic [31:0] i1);
    f_valid   = 1'b1;
    f_instr_0 = i0;
    f_instr_1 = i1;
  endtask

  task automatic idle();
    f_valid   = 1'b0;
    f_instr_0 = 32'h0;
    f_instr_1 = 32'h0;
  endtask

  task automatic do_reset();
    Reset     = 1'b1;
    idle();
    iss_ready = 1'b1;
    flush     = 1'b0;
    cyc();
    cyc();
    Reset = 1'b0;
  endtask

  task automatic chk_cnts(input string tag, input int d, input int s, input int st);
    chk({tag, "_cnt_dual"},   32'(cnt_dual),   32'(d));
    chk({tag, "_cnt_single"}, 32'(cnt_single), 32'(s));
    chk({tag, "_cnt_stall"},  32'(cnt_stall),  32'(st));
  endtask

  always @(negedge clk) begin
    if (!Reset && iss_ready && iss_valid_0) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_issue: got v1=%b i0=%h i1=%h, expected no issue (t=%0t)",
                 iss_valid_1, iss_instr_0, iss_instr_1, $time);
      end else begin
        e = exp_q.pop_front();
        chk("issue_v1", 32'(iss_valid_1), 32'(e.v1));
        chk("issue_i0", iss_instr_0, e.i0);
        chk("issue_i1", iss_instr_1, e.i1);
        $display("issue: v1=%b i0=%h i1=%h", iss_valid_1, iss_instr_0, iss_instr_1);
      end
    end
  end

  typedef struct {
    logic [31:0] i0;
    logic [31:0] i1;
    logic        dual;
  } pair_t;

  pair_t tbl[7];

  initial begin
    tbl[0] = '{ADD_3_4_5,  BEQ_1_2,   1'b1};  // control in slot 1 is allowed
    tbl[1] = '{ADD_1_2_3,  ADDI_1_4_7, 1'b0}; // WAW
    tbl[2] = '{ADD_0_2_3,  ADD_4_0_5, 1'b1};  // $0 dst is no hazard
    tbl[3] = '{LW_2_0_1,   ADD_4_5_6, 1'b1};  // one memory op only
    tbl[4] = '{ADDI_1_4_7, SW_3_4_1,  1'b0};  // RAW through rs of sw
    tbl[5] = '{32'h0,      32'h0,     1'b1};  // NOP pair
    tbl[6] = '{J_10,       ADD_4_5_6, 1'b0};  // control in slot 0

    Reset = 1'b1; f_valid = 1'b0; f_instr_0 = 32'h0; f_instr_1 = 32'h0;
    iss_ready = 1'b1; flush = 1'b0;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_valid_0", 32'(iss_valid_0), 32'd0);
    chk("rst_valid_1", 32'(iss_valid_1), 32'd0);
    chk("rst_instr_0", iss_instr_0, 32'h0);
    chk("rst_instr_1", iss_instr_1, 32'h0);
    chk("rst_f_ready", 32'(f_ready), 32'd1);
    chk_cnts("rst", 0, 0, 0);

    // 1: independent pair dual-issues one cycle after accept
    cyc();
    offer(ADD_1_2_3, ADD_4_5_6);
    push_exp(1'b1, ADD_1_2_3, ADD_4_5_6);
    @(negedge clk); chk("t1_f_ready_acc", 32'(f_ready), 32'd1);
    cyc(); idle();
    @(negedge clk); chk("t1_f_ready_iss", 32'(f_ready), 32'd1);
    cyc();
    @(negedge clk); chk_cnts("t1", 1, 0, 0);

    // 2: RAW pair split over two cycles
    do_reset();
    offer(ADD_1_2_3, SUB_4_1_5);
    push_exp(1'b0, ADD_1_2_3, 32'h0);
    push_exp(1'b0, SUB_4_1_5, 32'h0);
    cyc(); idle();
    @(negedge clk); chk("t2_f_ready_c1", 32'(f_ready), 32'd0);
    cyc();
    @(negedge clk); chk("t2_f_ready_c2", 32'(f_ready), 32'd1);
    cyc();
    @(negedge clk); chk_cnts("t2", 0, 2, 0);

    // 3: lw/sw split; a waiting pair is taken only once the buffer drains
    do_reset();
    offer(LW_2_0_1, SW_3_4_4);
    push_exp(1'b0, LW_2_0_1, 32'h0);
    push_exp(1'b0, SW_3_4_4, 32'h0);
    push_exp(1'b1, ADD_4_5_6, ADD_1_2_3);
    cyc(); offer(ADD_4_5_6, ADD_1_2_3);
    @(negedge clk); chk("t3_f_ready_c1", 32'(f_ready), 32'd0);
    cyc();
    @(negedge clk); chk("t3_f_ready_c2", 32'(f_ready), 32'd1);
    cyc(); idle();
    cyc();
    @(negedge clk); chk_cnts("t3", 1, 2, 0);

    // 4: backend stall holds the pair for 3 cycles
    do_reset();
    offer(ADD_1_2_3, ADD_4_5_6);
    push_exp(1'b1, ADD_1_2_3, ADD_4_5_6);
    cyc(); idle(); iss_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_hold_v0", 32'(iss_valid_0), 32'd1);
      chk("t4_hold_v1", 32'(iss_valid_1), 32'd1);
      chk("t4_hold_i0", iss_instr_0, ADD_1_2_3);
      chk("t4_hold_i1", iss_instr_1, ADD_4_5_6);
      chk("t4_f_ready", 32'(f_ready), 32'd0);
      cyc();
    end
    iss_ready = 1'b1;
    @(negedge clk); chk("t4_cnt_stall", 32'(cnt_stall), 32'd3);
    cyc();
    @(negedge clk); chk_cnts("t4", 1, 0, 3);

    // 5: flush in the cycle beq is presented discards the buffer
    do_reset();
    offer(BEQ_1_2, ADD_3_4_5);
    push_exp(1'b0, BEQ_1_2, 32'h0);
    cyc(); offer(ADD_4_5_6, ADD_1_2_3); flush = 1'b1;
    @(negedge clk); chk("t5_f_ready_flush", 32'(f_ready), 32'd0);
    cyc(); idle(); flush = 1'b0;
    @(negedge clk);
    chk("t5_valid_0", 32'(iss_valid_0), 32'd0);
    chk("t5_valid_1", 32'(iss_valid_1), 32'd0);
    chk("t5_f_ready_empty", 32'(f_ready), 32'd1);
    cyc();
    @(negedge clk); chk("t5_still_empty", 32'(iss_valid_0), 32'd0);

    // 7: hazard table
    for (int k = 0; k < 7; k++) begin
      do_reset();
      offer(tbl[k].i0, tbl[k].i1);
      if (tbl[k].dual) begin
        push_exp(1'b1, tbl[k].i0, tbl[k].i1);
      end else begin
        push_exp(1'b0, tbl[k].i0, 32'h0);
        push_exp(1'b0, tbl[k].i1, 32'h0);
      end
      cyc(); idle();
      cyc();
      if (!tbl[k].dual) cyc();
      @(negedge clk);
      chk($sformatf("t7_%0d_cnt_dual", k), 32'(cnt_dual), tbl[k].dual ? 32'd1 : 32'd0);
    end

    // 6: saturate all counters, then reset while SPLIT
    do_reset();
    for (int k = 0; k < 17; k++) begin
      offer(ADD_1_2_3, ADD_4_5_6);
      push_exp(1'b1, ADD_1_2_3, ADD_4_5_6);
      @(negedge clk); chk("t6_b2b_f_ready", 32'(f_ready), 32'd1);
      cyc();
    end
    idle();
    cyc();
    @(negedge clk); chk("t6_dual_sat", 32'(cnt_dual), 32'd15);

    offer(ADD_1_2_3, ADD_4_5_6);
    push_exp(1'b1, ADD_1_2_3, ADD_4_5_6);
    cyc(); idle(); iss_ready = 1'b0;
    for (int k = 0; k < 17; k++) cyc();
    iss_ready = 1'b1;
    cyc();
    @(negedge clk); chk("t6_stall_sat", 32'(cnt_stall), 32'd15);

    for (int k = 0; k < 8; k++) begin
      offer(ADD_1_2_3, SUB_4_1_5);
      push_exp(1'b0, ADD_1_2_3, 32'h0);
      push_exp(1'b0, SUB_4_1_5, 32'h0);
      cyc(); idle();
      cyc();
      cyc();
    end
    @(negedge clk); chk_cnts("t6_sat", 15, 15, 15);

    offer(ADD_1_2_3, SUB_4_1_5);
    push_exp(1'b0, ADD_1_2_3, 32'h0);
    cyc(); idle();
    cyc(); iss_ready = 1'b0; Reset = 1'b1;
    @(negedge clk);
    chk("t6_split_v0", 32'(iss_valid_0), 32'd1);
    chk("t6_split_i0", iss_instr_0, SUB_4_1_5);
    cyc(); Reset = 1'b0; iss_ready = 1'b1;
    @(negedge clk);
    chk("t6_post_v0", 32'(iss_valid_0), 32'd0);
    chk("t6_post_v1", 32'(iss_valid_1), 32'd0);
    chk("t6_post_i0", iss_instr_0, 32'h0);
    chk("t6_post_i1", iss_instr_1, 32'h0);
    chk_cnts("t6_post", 0, 0, 0);

    cyc();
    cyc();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
